// File: rtl/segment_display_pkg.sv
// Shared types and constants for the segment display arbiter and the digit driver it feeds.
package segment_display_pkg;
   localparam int SEG_DIGIT_WIDTH = 6;

   typedef logic [5:0] digit_code_t;

   localparam digit_code_t SEG_CODE_BLANK = 6'h20;

   typedef enum logic [0:0] {IDLE = 1'b0, SHOW = 1'b1} state_t;
endpackage

// File: rtl/segment_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting, non-excluded index after 'last', wrapping.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] last,
   input  logic [N-1:0]  exclude,
   output logic [IW-1:0] winner,
   output logic          found
);
   int            idx;
   logic [IW-1:0] sel;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      sel    = '0;
      // last itself is visited last, so the current owner only wins when nobody else asks
      for (int k = 1; k <= N; k++) begin
         idx = int'(last) + k;
         if (idx >= N) idx = idx - N;
         sel = idx[IW-1:0];
         if (!found && request[sel] && !exclude[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
   end
endmodule

// File: rtl/segment_display_arbiter.sv
// Round-robin owner selection of one shared 4-digit display with a minimum dwell per grant.
// Build option SEGMENT_ARBITER_PRIORITY_EN: a rising request[0] preempts any other owner.
//
// state | meaning
// IDLE  | nobody owns the display, digits blank
// SHOW  | grant[owner] set, dwell counter running or satisfied
module segment_display_arbiter
   import segment_display_pkg::*;
#(
   parameter int NUM_SOURCES = 3,
   parameter int NUM_DIGITS  = 4,
   parameter int DIGIT_WIDTH = SEG_DIGIT_WIDTH,
   parameter int DWELL_TICKS = 200
) (
   input  logic                                       clock,
   input  logic                                       reset,
   input  logic                                       tick,
   input  logic [NUM_SOURCES-1:0]                     request,
   input  logic [NUM_SOURCES*NUM_DIGITS*DIGIT_WIDTH-1:0] source_digits,
   output logic [DIGIT_WIDTH-1:0]                     digits [0:NUM_DIGITS-1],
   output logic [NUM_SOURCES-1:0]                     grant,
   output logic                                       grant_valid,
   output logic                                       dwell_done
);
   localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
   localparam int CW = $clog2(DWELL_TICKS + 1);
   localparam int FW = NUM_DIGITS * DIGIT_WIDTH;
   localparam logic [CW-1:0] RELOAD = CW'(DWELL_TICKS - 1);
   localparam logic [DIGIT_WIDTH-1:0] BLANK = DIGIT_WIDTH'(SEG_CODE_BLANK);
   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_SHOW = SHOW;

   logic [0:0]             state, state_nx;
   logic [IW-1:0]          last, last_nx, owner, owner_nx, pick_winner, take_src;
   logic [CW-1:0]          count, count_nx;
   logic [NUM_SOURCES-1:0] grant_nx;
   logic                   done_nx, pick_found, take, upd_last;

   rr_pick #(.N(NUM_SOURCES), .IW(IW)) u_pick (
      .request (request),
      .last    (last),
      .exclude (grant),
      .winner  (pick_winner),
      .found   (pick_found)
   );

`ifdef SEGMENT_ARBITER_PRIORITY_EN
   logic req0_q;

   always_ff @(posedge clock) begin
      if (reset) req0_q <= 1'b0;
      else       req0_q <= request[0];
   end
`endif

   always_comb begin
      state_nx = state;
      last_nx  = last;
      owner_nx = owner;
      count_nx = count;
      done_nx  = dwell_done;
      grant_nx = grant;
      take     = 1'b0;
      upd_last = 1'b1;
      take_src = pick_winner;
      if (state == S_IDLE) begin
         take = pick_found;
      end else if ((request & grant) == '0) begin
         // owner released: re-arbitrate now, a coincident tick is irrelevant
         take = pick_found;
         if (!pick_found) begin
            state_nx = S_IDLE;
            grant_nx = '0;
            count_nx = '0;
            done_nx  = 1'b0;
         end
      end else if (dwell_done && tick && pick_found) begin
         take = 1'b1;
      end else if (tick && count != '0) begin
         count_nx = count - CW'(1);
         done_nx  = (count == CW'(1));
      end
`ifdef SEGMENT_ARBITER_PRIORITY_EN
      // preemption leaves the pointer alone so rotation resumes where it was
      if (request[0] && !req0_q && state == S_SHOW && !grant[0]) begin
         take     = 1'b1;
         take_src = '0;
         upd_last = 1'b0;
      end
`endif
      if (take) begin
         state_nx = S_SHOW;
         grant_nx = NUM_SOURCES'(1) << take_src;
         owner_nx = take_src;
         count_nx = RELOAD;
         done_nx  = (DWELL_TICKS == 1);
         if (upd_last) last_nx = take_src;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         last       <= IW'(NUM_SOURCES - 1);
         owner      <= '0;
         count      <= '0;
         grant      <= '0;
         dwell_done <= 1'b0;
         for (int d = 0; d < NUM_DIGITS; d++) digits[d] <= BLANK;
      end else begin
         state      <= state_nx;
         last       <= last_nx;
         owner      <= owner_nx;
         count      <= count_nx;
         grant      <= grant_nx;
         dwell_done <= done_nx;
         // digits follow the next owner so they change on the same edge as grant
         for (int d = 0; d < NUM_DIGITS; d++)
            digits[d] <= (state_nx == S_IDLE) ? BLANK
                       : source_digits[int'(owner_nx)*FW + d*DIGIT_WIDTH +: DIGIT_WIDTH];
      end
   end

   assign grant_valid = (state == S_SHOW);
endmodule
